// File: rtl/stopwatch_ctrl_if.sv
// Button/status bundle between the debounced button front end and the stopwatch run control.
// The master drives button levels; the slave (stopwatch_ctrl) drives count and status outputs.
interface stopwatch_ctrl_if #(
  parameter int unsigned CNT_W = 19
);
  logic             btn_start;
  logic             btn_lap;
  logic             btn_clear;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] disp_count;
  logic [2:0]       state;
  logic             running;
  logic             frozen;
  logic             tick;
  logic             overflow;

  modport master (
    output btn_start, btn_lap, btn_clear,
    input  count, disp_count, state, running, frozen, tick, overflow
  );

  modport slave (
    input  btn_start, btn_lap, btn_clear,
    output count, disp_count, state, running, frozen, tick, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run control: button edge detect, tick prescaler, elapsed counter,
// lap freeze, clear and saturating auto-stop at MAX_COUNT.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV  = 1000000,
  parameter int unsigned CNT_W     = 19,
  parameter int unsigned MAX_COUNT = 359999
) (
  input logic             clk,
  input logic             reset,
  stopwatch_ctrl_if.slave sw
);

  localparam logic [2:0] StIdle     = 3'b000;
  localparam logic [2:0] StRun      = 3'b001;
  localparam logic [2:0] StPause    = 3'b010;
  localparam logic [2:0] StLap      = 3'b011;
  localparam logic [2:0] StLapPause = 3'b100;
  localparam logic [2:0] StDone     = 3'b101;

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0]  DivLast = DivW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(MAX_COUNT);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] lap_q, lap_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             tick_q, tick_d;
  logic             btn_start_q, btn_lap_q, btn_clear_q;

  logic press_start, press_lap, press_clear;
  logic is_running, is_frozen;
  logic tick_evt, last_tick;

  assign press_start = sw.btn_start & ~btn_start_q;
  assign press_lap   = sw.btn_lap & ~btn_lap_q;
  assign press_clear = sw.btn_clear & ~btn_clear_q;

  assign is_running = (state_q == StRun) || (state_q == StLap);
  assign is_frozen  = (state_q == StLap) || (state_q == StLapPause);
  assign tick_evt   = is_running && (div_q == DivLast);
  assign last_tick  = tick_evt && (count_q == CntMax - 1'b1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lap_d   = lap_q;
    div_d   = div_q;
    tick_d  = 1'b0;

    // Prescaler only moves while running; pausing holds sub-tick time.
    if (is_running) begin
      if (tick_evt) begin
        div_d   = '0;
        count_d = count_q + 1'b1;
        tick_d  = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (press_clear) begin
          count_d = '0;
          lap_d   = '0;
          div_d   = '0;
        end else if (press_start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (press_start) begin
          state_d = StPause;
        end else if (press_lap) begin
          state_d = StLap;
          lap_d   = count_q;
        end
      end
      StLap: begin
        if (press_start) begin
          state_d = StLapPause;
        end else if (press_lap) begin
          state_d = StRun;
        end
      end
      StPause: begin
        if (press_clear) begin
          state_d = StIdle;
          count_d = '0;
          lap_d   = '0;
          div_d   = '0;
        end else if (press_start) begin
          state_d = StRun;
        end
      end
      StLapPause: begin
        if (press_clear) begin
          state_d = StIdle;
          count_d = '0;
          lap_d   = '0;
          div_d   = '0;
        end else if (press_start) begin
          state_d = StLap;
        end else if (press_lap) begin
          state_d = StPause;
        end
      end
      StDone: begin
        if (press_clear) begin
          state_d = StIdle;
          count_d = '0;
          lap_d   = '0;
          div_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reaching the terminal count overrides any coincident start/lap press.
    if (last_tick) begin
      state_d = StDone;
      div_d   = '0;
      lap_d   = lap_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      lap_q       <= '0;
      div_q       <= '0;
      tick_q      <= 1'b0;
      btn_start_q <= 1'b1;
      btn_lap_q   <= 1'b1;
      btn_clear_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lap_q       <= lap_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      btn_start_q <= sw.btn_start;
      btn_lap_q   <= sw.btn_lap;
      btn_clear_q <= sw.btn_clear;
    end
  end

  assign sw.count      = count_q;
  assign sw.disp_count = is_frozen ? lap_q : count_q;
  assign sw.state      = state_q;
  assign sw.running    = is_running;
  assign sw.frozen     = is_frozen;
  assign sw.tick       = tick_q;
  assign sw.overflow   = (state_q == StDone);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (TICK_DIV=4, CNT_W=4, MAX_COUNT=10).
// Expected tick counts are queued when stimulus is applied and popped on each observed tick.
module tb_stopwatch_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [3:0] exp_q[$];

  stopwatch_ctrl_if #(.CNT_W(4)) sw ();

  stopwatch_ctrl #(
    .TICK_DIV (4),
    .CNT_W    (4),
    .MAX_COUNT(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait for the next tick; check its latency and the count it carries against the queue.
  task automatic wait_tick(input int exp_cycles, input string name);
    int cyc;
    logic [3:0] e;
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (sw.tick !== 1'b1 && cyc < exp_cycles + 4);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    checks++;
    if (sw.tick !== 1'b1) begin
      errors++;
      $display("FAIL %s: no tick within %0d cycles", name, exp_cycles + 4);
    end else begin
      checks++;
      if (sw.count !== e) begin
        errors++;
        $display("FAIL %s count: got %0d expected %0d", name, sw.count, e);
      end
      checks++;
      if (cyc != exp_cycles) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_cycles);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    sw.btn_start = 1'b1;
    sw.btn_lap   = 1'b0;
    sw.btn_clear = 1'b0;
    step(2);
    checks++;
    if (sw.state !== 3'b000 || sw.count !== 4'd0 || sw.tick !== 1'b0 || sw.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: state %0d count %0d tick %0d ovf %0d expected 0 0 0 0",
               sw.state, sw.count, sw.tick, sw.overflow);
    end
    reset = 1'b1;
    step(10);
    checks++;
    if (sw.state !== 3'b000 || sw.count !== 4'd0) begin
      errors++;
      $display("FAIL held_start: state %0d count %0d expected 0 0", sw.state, sw.count);
    end
    sw.btn_start = 1'b0;
    step(1);
    sw.btn_start = 1'b1;
    step(1);
    sw.btn_start = 1'b0;
    checks++;
    if (sw.state !== 3'b001 || sw.running !== 1'b1) begin
      errors++;
      $display("FAIL start_run: state %0d running %0d expected 1 1", sw.state, sw.running);
    end
    exp_q.push_back(4'd1);
    wait_tick(4, "first_tick");
  endtask

  task automatic test_pause;
    int stray;
    exp_q.push_back(4'd2);
    wait_tick(4, "tick2");
    exp_q.push_back(4'd3);
    wait_tick(4, "tick3");
    step(1);
    sw.btn_start = 1'b1;
    step(1);
    sw.btn_start = 1'b0;
    checks++;
    if (sw.state !== 3'b010 || sw.count !== 4'd3) begin
      errors++;
      $display("FAIL pause: state %0d count %0d expected 2 3", sw.state, sw.count);
    end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (sw.tick !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0 || sw.count !== 4'd3) begin
      errors++;
      $display("FAIL paused_hold: ticks %0d count %0d expected 0 3", stray, sw.count);
    end
    sw.btn_start = 1'b1;
    step(1);
    sw.btn_start = 1'b0;
    exp_q.push_back(4'd4);
    wait_tick(2, "resume_tick");
  endtask

  task automatic test_lap;
    exp_q.push_back(4'd5);
    wait_tick(4, "tick5");
    sw.btn_lap = 1'b1;
    step(1);
    sw.btn_lap = 1'b0;
    checks++;
    if (sw.state !== 3'b011 || sw.frozen !== 1'b1 || sw.disp_count !== 4'd5) begin
      errors++;
      $display("FAIL lap_enter: state %0d frozen %0d disp %0d expected 3 1 5",
               sw.state, sw.frozen, sw.disp_count);
    end
    exp_q.push_back(4'd6);
    wait_tick(3, "lap_tick6");
    exp_q.push_back(4'd7);
    wait_tick(4, "lap_tick7");
    checks++;
    if (sw.disp_count !== 4'd5) begin
      errors++;
      $display("FAIL lap_frozen_disp: got %0d expected 5", sw.disp_count);
    end
    sw.btn_lap = 1'b1;
    step(1);
    sw.btn_lap = 1'b0;
    checks++;
    if (sw.state !== 3'b001 || sw.frozen !== 1'b0 || sw.disp_count !== 4'd7
        || sw.count !== 4'd7) begin
      errors++;
      $display("FAIL lap_release: state %0d frozen %0d disp %0d count %0d expected 1 0 7 7",
               sw.state, sw.frozen, sw.disp_count, sw.count);
    end
  endtask

  task automatic test_priority;
    sw.btn_start = 1'b1;
    sw.btn_lap   = 1'b1;
    sw.btn_clear = 1'b1;
    step(1);
    sw.btn_start = 1'b0;
    sw.btn_lap   = 1'b0;
    sw.btn_clear = 1'b0;
    checks++;
    if (sw.state !== 3'b010 || sw.frozen !== 1'b0 || sw.count !== 4'd7
        || sw.disp_count !== 4'd7) begin
      errors++;
      $display("FAIL prio_start: state %0d frozen %0d count %0d disp %0d expected 2 0 7 7",
               sw.state, sw.frozen, sw.count, sw.disp_count);
    end
    step(1);
    sw.btn_clear = 1'b1;
    step(1);
    sw.btn_clear = 1'b0;
    checks++;
    if (sw.state !== 3'b000 || sw.count !== 4'd0 || sw.disp_count !== 4'd0) begin
      errors++;
      $display("FAIL pause_clear: state %0d count %0d disp %0d expected 0 0 0",
               sw.state, sw.count, sw.disp_count);
    end
  endtask

  task automatic test_saturate;
    int stray;
    sw.btn_start = 1'b1;
    step(1);
    sw.btn_start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      exp_q.push_back(4'(i));
      wait_tick(4, "sat_run");
    end
    step(3);
    // Start lands on the same edge as the final tick; the tick must win.
    exp_q.push_back(4'd10);
    sw.btn_start = 1'b1;
    step(1);
    sw.btn_start = 1'b0;
    checks++;
    if (sw.tick !== 1'b1 || sw.count !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL final_tick: tick %0d count %0d expected 1 10", sw.tick, sw.count);
    end
    checks++;
    if (sw.state !== 3'b101 || sw.overflow !== 1'b1 || sw.running !== 1'b0) begin
      errors++;
      $display("FAIL done: state %0d ovf %0d running %0d expected 5 1 0",
               sw.state, sw.overflow, sw.running);
    end
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (sw.tick !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0 || sw.count !== 4'd10) begin
      errors++;
      $display("FAIL done_hold: ticks %0d count %0d expected 0 10", stray, sw.count);
    end
    sw.btn_start = 1'b1;
    step(1);
    sw.btn_start = 1'b0;
    step(1);
    sw.btn_lap = 1'b1;
    step(1);
    sw.btn_lap = 1'b0;
    checks++;
    if (sw.state !== 3'b101 || sw.count !== 4'd10) begin
      errors++;
      $display("FAIL done_ignore: state %0d count %0d expected 5 10", sw.state, sw.count);
    end
    step(1);
    sw.btn_clear = 1'b1;
    step(1);
    sw.btn_clear = 1'b0;
    checks++;
    if (sw.state !== 3'b000 || sw.overflow !== 1'b0 || sw.count !== 4'd0) begin
      errors++;
      $display("FAIL done_clear: state %0d ovf %0d count %0d expected 0 0 0",
               sw.state, sw.overflow, sw.count);
    end
  endtask

  task automatic test_async_reset;
    step(1);
    sw.btn_start = 1'b1;
    step(1);
    sw.btn_start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      exp_q.push_back(4'(i));
      wait_tick(4, "rst_run");
    end
    sw.btn_lap = 1'b1;
    step(1);
    sw.btn_lap = 1'b0;
    checks++;
    if (sw.state !== 3'b011 || sw.count !== 4'd6) begin
      errors++;
      $display("FAIL pre_reset_lap: state %0d count %0d expected 3 6", sw.state, sw.count);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (sw.state !== 3'b000 || sw.count !== 4'd0 || sw.disp_count !== 4'd0
        || sw.tick !== 1'b0 || sw.overflow !== 1'b0 || sw.running !== 1'b0
        || sw.frozen !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state %0d count %0d disp %0d tick %0d ovf %0d run %0d frz %0d expected all 0",
               sw.state, sw.count, sw.disp_count, sw.tick, sw.overflow, sw.running, sw.frozen);
    end
    step(2);
    reset = 1'b1;
    step(3);
    checks++;
    if (sw.state !== 3'b000 || sw.count !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_idle: state %0d count %0d expected 0 0", sw.state, sw.count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_pause();
    test_lap();
    test_priority();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
